// File: rtl/timer_tima_if.sv
// CPU register bus between the FF04..FF07 decode and the timer block.
// The CPU side drives address/strobes/data; the timer returns read data and its bus enable.
interface timer_tima_if;
  logic       ff04_ff07;
  logic [1:0] a;
  logic       cpu_wr;
  logic       cpu_rd;
  logic [7:0] d_in;
  logic [7:0] d_out;
  logic       d_oe;

  modport master (
    output ff04_ff07, a, cpu_wr, cpu_rd, d_in,
    input  d_out, d_oe
  );

  modport slave (
    input  ff04_ff07, a, cpu_wr, cpu_rd, d_in,
    output d_out, d_oe
  );
endinterface

// File: rtl/timer_tima.sv
// DMG timer: TIMA/TMA/TAC registers, divider-tap edge counter and delayed overflow reload.
// Define TIMER_TAC_GLITCH_EN to let TAC writes produce the hardware's spurious tick.
module timer_tima #(
  parameter int unsigned RELOAD_DELAY = 4
) (
  input  logic         clk,
  input  logic         nreset,
  input  logic         tap_4096,
  input  logic         tap_262144,
  input  logic         tap_65536,
  input  logic         tap_16384,
  timer_tima_if.slave  bus,
  output logic         int_timer,
  output logic [7:0]   tima_q
);

  logic [7:0] tima_d;
  logic [7:0] tma_q, tma_d;
  logic [2:0] tac_q, tac_d;
  logic [3:0] cnt_q, cnt_d;
  logic       sig_q, sig_d;
  logic       int_q, int_d;

  logic [3:0] taps;
  logic       sig;
  logic       tick;
  logic       wr, wr_tima, wr_tma, wr_tac;

  assign taps    = {tap_16384, tap_65536, tap_262144, tap_4096};
  assign sig     = tac_q[2] & taps[tac_q[1:0]];
  assign tick    = sig_q & ~sig;

  assign wr      = bus.cpu_wr & bus.ff04_ff07;
  assign wr_tima = wr & (bus.a == 2'd1);
  assign wr_tma  = wr & (bus.a == 2'd2);
  assign wr_tac  = wr & (bus.a == 2'd3);

`ifdef TIMER_TAC_GLITCH_EN
  assign sig_d = sig;
`else
  // Pre-load the edge detector with the post-write level so a TAC write never ticks.
  logic sig_new;
  assign sig_new = bus.d_in[2] & taps[bus.d_in[1:0]];
  assign sig_d   = wr_tac ? sig_new : sig;
`endif

  always_comb begin
    tima_d = tima_q;
    tma_d  = tma_q;
    tac_d  = tac_q;
    cnt_d  = cnt_q;
    int_d  = 1'b0;

    if (cnt_q != 4'd0) begin
      cnt_d = cnt_q - 4'd1;
    end

    if (tick) begin
      if (tima_q == 8'hff) begin
        tima_d = 8'h00;
        cnt_d  = 4'(RELOAD_DELAY);
      end else begin
        tima_d = tima_q + 8'd1;
      end
    end

    if (wr_tma) begin
      tma_d = bus.d_in;
    end
    if (wr_tac) begin
      tac_d = bus.d_in[2:0];
    end

    // The reload edge takes priority over a TIMA write; a same-edge TMA write passes through.
    if (cnt_q == 4'd1) begin
      tima_d = wr_tma ? bus.d_in : tma_q;
      int_d  = 1'b1;
      cnt_d  = 4'd0;
    end else if (wr_tima) begin
      tima_d = bus.d_in;
      cnt_d  = 4'd0;
    end
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      tima_q <= 8'h00;
      tma_q  <= 8'h00;
      tac_q  <= 3'b000;
      cnt_q  <= 4'd0;
      sig_q  <= 1'b0;
      int_q  <= 1'b0;
    end else begin
      tima_q <= tima_d;
      tma_q  <= tma_d;
      tac_q  <= tac_d;
      cnt_q  <= cnt_d;
      sig_q  <= sig_d;
      int_q  <= int_d;
    end
  end

  assign int_timer = int_q;

  always_comb begin
    bus.d_oe  = 1'b0;
    bus.d_out = 8'h00;
    if (bus.cpu_rd && bus.ff04_ff07 && (bus.a != 2'd0)) begin
      bus.d_oe = 1'b1;
      case (bus.a)
        2'd1:    bus.d_out = tima_q;
        2'd2:    bus.d_out = tma_q;
        default: bus.d_out = {5'b11111, tac_q};
      endcase
    end
  end

endmodule

// File: tb/tb_timer_tima.sv
// Self-checking bench for timer_tima: register table, directed corner sequences and a
// randomized run checked against a timestamp-based reference model.
module tb_timer_tima;
  localparam int unsigned RD = 4;

  logic       clk = 1'b0;
  logic       nreset = 1'b0;
  logic       tap_4096 = 1'b0;
  logic       tap_262144 = 1'b0;
  logic       tap_65536 = 1'b0;
  logic       tap_16384 = 1'b0;
  logic       int_timer;
  logic [7:0] tima_q;

  timer_tima_if bus();

  timer_tima #(.RELOAD_DELAY(RD)) dut (
    .clk        (clk),
    .nreset     (nreset),
    .tap_4096   (tap_4096),
    .tap_262144 (tap_262144),
    .tap_65536  (tap_65536),
    .tap_16384  (tap_16384),
    .bus        (bus),
    .int_timer  (int_timer),
    .tima_q     (tima_q)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: reload scheduled as an absolute edge number.
  logic [7:0] m_tima, m_tma;
  logic [2:0] m_tac;
  logic       m_prev, m_int;
  int         m_reload;
  int         cyc = 0;

  task automatic chk8(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %b expected %b (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic tap_of(input logic [1:0] s);
    case (s)
      2'd0:    return tap_4096;
      2'd1:    return tap_262144;
      2'd2:    return tap_65536;
      default: return tap_16384;
    endcase
  endfunction

  task automatic model_reset();
    m_tima = 8'h00; m_tma = 8'h00; m_tac = 3'b000;
    m_prev = 1'b0; m_int = 1'b0; m_reload = -1;
  endtask

  task automatic model_read(output logic oe, output logic [7:0] dout);
    oe = 1'b0; dout = 8'h00;
    if (bus.cpu_rd && bus.ff04_ff07 && bus.a != 2'd0) begin
      oe = 1'b1;
      dout = (bus.a == 2'd1) ? m_tima : (bus.a == 2'd2) ? m_tma : {5'b11111, m_tac};
    end
  endtask

  task automatic model_step();
    logic       wr, sig_now, tick;
    logic [7:0] n_tima;
    wr      = bus.cpu_wr & bus.ff04_ff07;
    sig_now = m_tac[2] & tap_of(m_tac[1:0]);
    tick    = m_prev & ~sig_now;
    n_tima  = m_tima;
    m_int   = 1'b0;
    if (m_reload == cyc) begin
      n_tima = (wr && bus.a == 2'd2) ? bus.d_in : m_tma;
      m_int = 1'b1;
      m_reload = -1;
    end else if (wr && bus.a == 2'd1) begin
      n_tima = bus.d_in;
      m_reload = -1;
    end else if (tick) begin
      if (m_tima == 8'hff) begin
        n_tima = 8'h00;
        m_reload = cyc + int'(RD);
      end else begin
        n_tima = m_tima + 8'd1;
      end
    end
    m_prev = sig_now;
    if (wr && bus.a == 2'd2) m_tma = bus.d_in;
    if (wr && bus.a == 2'd3) begin
      m_tac = bus.d_in[2:0];
`ifndef TIMER_TAC_GLITCH_EN
      m_prev = m_tac[2] & tap_of(m_tac[1:0]);
`endif
    end
    m_tima = n_tima;
    cyc++;
  endtask

  // One clock: check reads before the edge, advance model, check state after the edge.
  task automatic cycle();
    logic       eoe;
    logic [7:0] edo;
    #1;
    model_read(eoe, edo);
    chk1("d_oe", bus.d_oe, eoe);
    chk8("d_out", bus.d_out, edo);
    model_step();
    @(posedge clk);
    #1;
    chk8("tima_q", tima_q, m_tima);
    chk1("int_timer", int_timer, m_int);
  endtask

  task automatic bus_idle();
    bus.ff04_ff07 = 1'b0; bus.a = 2'd0; bus.cpu_wr = 1'b0; bus.cpu_rd = 1'b0; bus.d_in = 8'h00;
  endtask

  task automatic wr(input logic [1:0] a, input logic [7:0] d);
    bus.ff04_ff07 = 1'b1; bus.a = a; bus.cpu_wr = 1'b1; bus.d_in = d;
    cycle();
    bus_idle();
  endtask

  task automatic rd_chk(input string name, input logic [1:0] a, input logic [7:0] exp);
    bus.ff04_ff07 = 1'b1; bus.a = a; bus.cpu_rd = 1'b1;
    #1;
    chk1({name, "_oe"}, bus.d_oe, 1'b1);
    chk8(name, bus.d_out, exp);
    cycle();
    bus_idle();
  endtask

  task automatic pulse262();
    tap_262144 = 1'b1;
    cycle();
    tap_262144 = 1'b0;
    cycle();
  endtask

  task automatic do_reset(input string tag);
    nreset = 1'b0;
    bus_idle();
    #1;
    chk8({tag, "_rst_tima"}, tima_q, 8'h00);
    chk1({tag, "_rst_int"}, int_timer, 1'b0);
    chk1({tag, "_rst_oe"}, bus.d_oe, 1'b0);
    bus.cpu_rd = 1'b1; bus.ff04_ff07 = 1'b1; bus.a = 2'd2;
    #1;
    chk8({tag, "_rst_tma"}, bus.d_out, 8'h00);
    bus.a = 2'd3;
    #1;
    chk8({tag, "_rst_tac"}, bus.d_out, 8'hf8);
    bus_idle();
    nreset = 1'b1;
    model_reset();
  endtask

  typedef struct {
    logic       wr;
    logic       rd;
    logic       ff;
    logic [1:0] a;
    logic [7:0] din;
    logic       exp_oe;
    logic [7:0] exp_do;
  } vec_t;

  vec_t vecs[$];

  initial begin
    bus_idle();
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    do_reset("init");

    // Register access table; taps are all low so nothing counts.
    vecs.push_back('{1'b1, 1'b0, 1'b1, 2'd2, 8'h5a, 1'b0, 8'h00});
    vecs.push_back('{1'b0, 1'b1, 1'b1, 2'd2, 8'h00, 1'b1, 8'h5a});
    vecs.push_back('{1'b1, 1'b0, 1'b1, 2'd3, 8'h05, 1'b0, 8'h00});
    vecs.push_back('{1'b0, 1'b1, 1'b1, 2'd3, 8'h00, 1'b1, 8'hfd});
    vecs.push_back('{1'b0, 1'b1, 1'b1, 2'd0, 8'h00, 1'b0, 8'h00});
    vecs.push_back('{1'b1, 1'b0, 1'b0, 2'd2, 8'h11, 1'b0, 8'h00});
    vecs.push_back('{1'b0, 1'b1, 1'b1, 2'd2, 8'h00, 1'b1, 8'h5a});
    vecs.push_back('{1'b1, 1'b0, 1'b1, 2'd3, 8'hfa, 1'b0, 8'h00});
    vecs.push_back('{1'b0, 1'b1, 1'b1, 2'd3, 8'h00, 1'b1, 8'hfa});
    vecs.push_back('{1'b1, 1'b0, 1'b1, 2'd1, 8'h3c, 1'b0, 8'h00});
    vecs.push_back('{1'b0, 1'b1, 1'b1, 2'd1, 8'h00, 1'b1, 8'h3c});
    vecs.push_back('{1'b0, 1'b1, 1'b0, 2'd1, 8'h00, 1'b0, 8'h00});
    vecs.push_back('{1'b1, 1'b0, 1'b1, 2'd0, 8'hff, 1'b0, 8'h00});
    vecs.push_back('{1'b0, 1'b1, 1'b1, 2'd1, 8'h00, 1'b1, 8'h3c});
    foreach (vecs[i]) begin
      bus.cpu_wr = vecs[i].wr; bus.cpu_rd = vecs[i].rd; bus.ff04_ff07 = vecs[i].ff;
      bus.a = vecs[i].a; bus.d_in = vecs[i].din;
      #1;
      chk1($sformatf("vec%0d_oe", i), bus.d_oe, vecs[i].exp_oe);
      chk8($sformatf("vec%0d_do", i), bus.d_out, vecs[i].exp_do);
      cycle();
      bus_idle();
    end

    // Overflow with full reload delay.
    wr(2'd3, 8'h05); wr(2'd1, 8'hfe); wr(2'd2, 8'h80);
    pulse262();
    chk8("s1_ff", tima_q, 8'hff);
    pulse262();
    chk8("s1_wrap", tima_q, 8'h00);
    chk1("s1_noint0", int_timer, 1'b0);
    for (int k = 1; k < int'(RD); k++) begin
      cycle();
      chk8("s1_hold", tima_q, 8'h00);
      chk1("s1_noint", int_timer, 1'b0);
    end
    cycle();
    chk8("s1_reload", tima_q, 8'h80);
    chk1("s1_int", int_timer, 1'b1);
    cycle();
    chk1("s1_int_once", int_timer, 1'b0);

    // TIMA write inside the window cancels the reload.
    wr(2'd1, 8'hff);
    pulse262();
    cycle();
    wr(2'd1, 8'h33);
    chk8("s2_wr", tima_q, 8'h33);
    for (int k = 0; k < int'(RD) + 2; k++) begin
      cycle();
      chk1("s2_noint", int_timer, 1'b0);
      chk8("s2_keep", tima_q, 8'h33);
    end

    // TMA write on the reload clock passes through to TIMA.
    wr(2'd1, 8'hff);
    pulse262();
    repeat (RD - 1) cycle();
    wr(2'd2, 8'hc5);
    chk8("s3_thru", tima_q, 8'hc5);
    chk1("s3_int", int_timer, 1'b1);
    cycle();
    chk1("s3_int_once", int_timer, 1'b0);
    rd_chk("s3_tma", 2'd2, 8'hc5);

    // Disabling the timer while the selected tap is high.
    wr(2'd1, 8'h10);
    wr(2'd3, 8'h04);
    tap_4096 = 1'b1;
    cycle(); cycle();
    wr(2'd3, 8'h00);
    cycle();
`ifdef TIMER_TAC_GLITCH_EN
    chk8("s4_glitch", tima_q, 8'h11);
`else
    chk8("s4_noglitch", tima_q, 8'h10);
`endif
    tap_4096 = 1'b0;
    cycle();

    // DIV reset dropping the taps is a real tick.
    wr(2'd1, 8'h20);
    tap_65536 = 1'b1;
    wr(2'd3, 8'h06);
    cycle();
    tap_4096 = 1'b0; tap_262144 = 1'b0; tap_65536 = 1'b0; tap_16384 = 1'b0;
    cycle();
    chk8("s5_divtick", tima_q, 8'h21);

    // Reset in the middle of a reload window.
    wr(2'd3, 8'h05); wr(2'd2, 8'h77); wr(2'd1, 8'hff);
    pulse262();
    cycle();
    do_reset("s6");
    for (int k = 0; k < int'(RD) + 2; k++) begin
      cycle();
      chk1("s6_noint", int_timer, 1'b0);
      chk8("s6_zero", tima_q, 8'h00);
    end

    // Randomized traffic against the model.
    for (int i = 0; i < 4000; i++) begin
      int unsigned r;
      r = $urandom_range(0, 999);
      if (r == 999) do_reset("rnd");
      if ($urandom_range(0, 3) == 0) tap_262144 = ~tap_262144;
      if ($urandom_range(0, 15) == 0) tap_65536 = ~tap_65536;
      if ($urandom_range(0, 31) == 0) tap_16384 = ~tap_16384;
      if ($urandom_range(0, 63) == 0) tap_4096 = ~tap_4096;
      if ($urandom_range(0, 199) == 0) begin
        tap_4096 = 1'b0; tap_262144 = 1'b0; tap_65536 = 1'b0; tap_16384 = 1'b0;
      end
      bus_idle();
      r = $urandom_range(0, 99);
      bus.ff04_ff07 = ($urandom_range(0, 9) != 0);
      if (r < 4) begin
        bus.cpu_wr = 1'b1; bus.a = 2'd3; bus.d_in = 8'($urandom);
      end else if (r < 9) begin
        bus.cpu_wr = 1'b1; bus.a = 2'd1; bus.d_in = 8'($urandom_range(240, 255));
      end else if (r < 12) begin
        bus.cpu_wr = 1'b1; bus.a = 2'd2; bus.d_in = 8'($urandom);
      end else if (r < 45) begin
        bus.cpu_rd = 1'b1; bus.a = 2'($urandom_range(0, 3));
        bus.cpu_wr = ($urandom_range(0, 7) == 0);
        bus.d_in = 8'($urandom);
      end
      cycle();
    end
    bus_idle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
